// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the 4-way round-robin packet arbiter.
// Also provides the rotating-priority search used to pick the next grant.
package mux_arb_pkg;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned SEL_W   = 2;

    typedef enum logic [0:0] {
        StIdle,
        StGrant
    } arb_state_e;

    // First set bit of req at or after ptr, wrapping modulo NUM_REQ.
    function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                 input logic [SEL_W-1:0]   ptr);
        logic [SEL_W-1:0] idx;
        logic [SEL_W-1:0] pick;
        logic             found;
        pick  = ptr;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = ptr + SEL_W'(i);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/mux_4to1.sv
// Plain 4:1 data multiplexer; the arbiter steers valid/last/ready itself.
module mux_4to1 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [1:0]         sel_i,
    input  logic [4*WIDTH-1:0] data_i,
    output logic [WIDTH-1:0]   data_o
);

    always_comb begin
        unique case (sel_i)
            2'd0:    data_o = data_i[0*WIDTH +: WIDTH];
            2'd1:    data_o = data_i[1*WIDTH +: WIDTH];
            2'd2:    data_o = data_i[2*WIDTH +: WIDTH];
            default: data_o = data_i[3*WIDTH +: WIDTH];
        endcase
    end

endmodule

// File: rtl/mux_4to1_rr_arbiter.sv
// Round-robin packet arbiter sharing one valid/ready/last channel between 4 producers.
// Define ARB_TIMEOUT_EN to force a grant release after TIMEOUT cycles without a transfer.
module mux_4to1_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [3:0]           req_valid,
    input  logic [4*WIDTH-1:0]   req_data,
    input  logic [3:0]           req_last,
    output logic [3:0]           req_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_last,
    input  logic                 out_ready,
    output logic [1:0]           sel,
    output logic [3:0]           grant,
    output logic                 busy,
    output logic                 timeout
);

    arb_state_e           state_q, state_d;
    logic [SEL_W-1:0]     ptr_q, ptr_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic                 xfer;
    logic                 force_rel;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            sel_q   <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        grant_d = grant_q;
        unique case (state_q)
            StIdle: begin
                if (|req_valid) begin
                    sel_d          = rr_pick(req_valid, ptr_q);
                    grant_d        = '0;
                    grant_d[sel_d] = 1'b1;
                    state_d        = StGrant;
                end
            end
            StGrant: begin
                // Priority rotates past the port just served, whatever ended its packet.
                if ((xfer && out_last) || force_rel) begin
                    state_d = StIdle;
                    grant_d = '0;
                    ptr_d   = sel_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        out_valid = 1'b0;
        out_last  = 1'b0;
        req_ready = '0;
        if (state_q == StGrant) begin
            out_valid        = req_valid[sel_q];
            out_last         = req_last[sel_q];
            req_ready[sel_q] = out_ready;
        end
    end

    assign xfer  = out_valid & out_ready;
    assign busy  = (state_q == StGrant);
    assign sel   = sel_q;
    assign grant = grant_q;

    mux_4to1 #(
        .WIDTH (WIDTH)
    ) u_mux (
        .sel_i  (sel_q),
        .data_i (req_data),
        .data_o (out_data)
    );

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            timeout_q;

    // Idle clears the count so every new grant starts from zero.
    always_comb begin
        if (state_q == StIdle || xfer) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign force_rel = (state_q == StGrant) && !xfer && (cnt_q == CntW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= force_rel;
        end
    end

    assign timeout = timeout_q;
`else
    assign force_rel = 1'b0;
    assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_mux_4to1_rr_arbiter.sv
// Scoreboard bench for mux_4to1_rr_arbiter: directed packet streams with hand-computed
// grant sequences; a negedge monitor checks every transfer against the expected queue.
module tb_mux_4to1_rr_arbiter;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [3:0]     req_valid;
    logic [4*W-1:0] req_data;
    logic [3:0]     req_last;
    logic [3:0]     req_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic           out_last;
    logic           out_ready;
    logic [1:0]     sel;
    logic [3:0]     grant;
    logic           busy;
    logic           timeout;

    mux_4to1_rr_arbiter #(
        .WIDTH   (W),
        .TIMEOUT (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .sel       (sel),
        .grant     (grant),
        .busy      (busy),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] g;
        logic [7:0] d;
        logic       l;
    } exp_t;

    exp_t       exp_q[$];
    int         vectors = 0;
    int         miscompares = 0;
    int         npk[4];
    int         plen[4];
    int         beat[4];
    int         pkt[4];
    bit         drop[4];
    logic [3:0] fire_s = '0;
    logic [4:0] bad_s;
    exp_t       mon_e;

    logic [3:0] g2 [12] = '{4'b0010, 4'b0010, 4'b0000, 4'b1000, 4'b1000, 4'b0000,
                            4'b0010, 4'b0010, 4'b0000, 4'b1000, 4'b1000, 4'b0000};
    logic [3:0] g3 [16] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000,
                            4'b1000, 4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b0000,
                            4'b0100, 4'b0000, 4'b1000, 4'b0000};

    function automatic logic [7:0] mk(input int p, input int k, input int b);
        return {p[1:0], k[2:0], b[2:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            req_valid[i]       = (npk[i] > 0) && !drop[i];
            req_data[i*W +: W] = mk(i, pkt[i], beat[i]);
            req_last[i]        = (beat[i] == plen[i] - 1);
        end
    endtask

    task automatic load(input int p, input int n, input int l);
        npk[p]  = n;
        plen[p] = l;
        pkt[p]  = 0;
        beat[p] = 0;
        drop[p] = 1'b0;
        drive();
    endtask

    task automatic expect_pkt(input int p, input int k, input int l);
        exp_t e;
        for (int b = 0; b < l; b++) begin
            e.g = 4'b0001 << p;
            e.d = mk(p, k, b);
            e.l = (b == l - 1);
            exp_q.push_back(e);
        end
    endtask

    // Producers advance on handshakes seen by the monitor in the previous cycle.
    task automatic cycle();
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (fire_s[i]) begin
                if (beat[i] == plen[i] - 1) begin
                    beat[i] = 0;
                    pkt[i]++;
                    npk[i]--;
                end else begin
                    beat[i]++;
                end
            end
        end
        drive();
        #1;
    endtask

    always @(negedge clk) begin
        fire_s = req_valid & req_ready;
        bad_s  = {(grant == 4'b0000) && out_valid, req_ready & ~grant};
        chk("ready_gating", 32'(bad_s), 32'd0);
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_xfer", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("xfer_grant", 32'(grant), 32'(mon_e.g));
                chk("xfer_data", 32'(out_data), 32'(mon_e.d));
                chk("xfer_last", 32'(out_last), 32'(mon_e.l));
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) load(i, 0, 1);
        cycle();
        cycle();
        rst_n = 1'b1;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);

        // No requests: stays idle.
        out_ready = 1'b1;
        for (int j = 0; j < 10; j++) begin
            cycle();
            chk("idle_grant", 32'(grant), 32'd0);
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_out_valid", 32'(out_valid), 32'd0);
            chk("idle_req_ready", 32'(req_ready), 32'd0);
        end

        // Ports 1 and 3, two 2-beat packets each.
        expect_pkt(1, 0, 2);
        expect_pkt(3, 0, 2);
        expect_pkt(1, 1, 2);
        expect_pkt(3, 1, 2);
        load(1, 2, 2);
        load(3, 2, 2);
        for (int j = 0; j < 12; j++) begin
            cycle();
            chk("t2_grant", 32'(grant), 32'(g2[j]));
        end

        // All four ports, two single-beat packets each.
        for (int k = 0; k < 2; k++)
            for (int p = 0; p < 4; p++) expect_pkt(p, k, 1);
        for (int i = 0; i < 4; i++) load(i, 2, 1);
        for (int j = 0; j < 16; j++) begin
            cycle();
            chk("t3_grant", 32'(grant), 32'(g3[j]));
        end

        // Port 2 stalled by the consumer for 5 cycles.
        out_ready = 1'b0;
        expect_pkt(2, 0, 1);
        load(2, 1, 1);
        for (int j = 0; j < 5; j++) begin
            cycle();
            req_data[0 +: W] = 8'(j * 37 + 5);
            #1;
            chk("t4_stall_grant", 32'(grant), 32'b0100);
            chk("t4_stall_ready", 32'(req_ready), 32'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("t4_ready", 32'(req_ready), 32'b0100);
        cycle();
        chk("t4_release_grant", 32'(grant), 32'd0);
        chk("t4_release_busy", 32'(busy), 32'd0);

        // Reset on beat 2 of a 4-beat packet from port 1.
        for (int b = 0; b < 2; b++) begin
            mon_e.g = 4'b0010;
            mon_e.d = mk(1, 0, b);
            mon_e.l = 1'b0;
            exp_q.push_back(mon_e);
        end
        load(1, 1, 4);
        cycle();
        chk("t5_grant", 32'(grant), 32'b0010);
        cycle();
        cycle();
        chk("t5_beat2_data", 32'(out_data), 32'(mk(1, 0, 2)));
        rst_n     = 1'b0;
        out_ready = 1'b0;
        cycle();
        chk("t5_rst_grant", 32'(grant), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_sel", 32'(sel), 32'd0);
        chk("t5_rst_out_valid", 32'(out_valid), 32'd0);
        chk("t5_rst_req_ready", 32'(req_ready), 32'd0);
        for (int i = 0; i < 4; i++) load(i, 0, 1);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int p = 0; p < 4; p++) expect_pkt(p, 0, 1);
        for (int i = 0; i < 4; i++) load(i, 1, 1);
        cycle();
        chk("t5_first_grant", 32'(grant), 32'b0001);
        repeat (7) cycle();

`ifdef ARB_TIMEOUT_EN
        // Port 3 granted then drops valid without last.
        load(3, 1, 2);
        cycle();
        chk("t6_grant", 32'(grant), 32'b1000);
        drop[3] = 1'b1;
        drive();
        for (int j = 0; j < 15; j++) begin
            cycle();
            chk("t6_hold_grant", 32'(grant), 32'b1000);
            chk("t6_hold_timeout", 32'(timeout), 32'd0);
        end
        cycle();
        chk("t6_to_pulse", 32'(timeout), 32'd1);
        chk("t6_to_grant", 32'(grant), 32'd0);
        chk("t6_to_busy", 32'(busy), 32'd0);
        expect_pkt(0, 0, 1);
        expect_pkt(3, 0, 1);
        load(0, 1, 1);
        load(3, 1, 1);
        cycle();
        chk("t6_pulse_end", 32'(timeout), 32'd0);
        chk("t6_next_grant", 32'(grant), 32'b0001);
        repeat (3) cycle();
`else
        chk("no_timeout", 32'(timeout), 32'd0);
`endif

        repeat (2) cycle();
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
